// File: rtl/regfile_bypass_if.sv
// ---------------------------------------------------------------------------
// regfile_bypass_if
//   Bus bundle between the writeback/decode stages and the register file.
//
//   Signals:
//     ReadRegister  [NUM_READ*ADDR_W]  read addresses, port p at [p*ADDR_W +: ADDR_W]
//     WriteRegister [ADDR_W]           write address
//     WriteData     [DATA_W]           write data
//     RegWrite                         write enable
//     ReadData      [NUM_READ*DATA_W]  read data, port p at [p*DATA_W +: DATA_W]
//     Ready                            clear sequence finished, file usable
//
//   Modports:
//     master : pipeline side (drives addresses / write data)
//     slave  : register file side
// ---------------------------------------------------------------------------
interface regfile_bypass_if #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] ReadRegister;
  logic [ADDR_W-1:0]          WriteRegister;
  logic [DATA_W-1:0]          WriteData;
  logic                       RegWrite;
  logic [NUM_READ*DATA_W-1:0] ReadData;
  logic                       Ready;

  modport master (
    output ReadRegister,
    output WriteRegister,
    output WriteData,
    output RegWrite,
    input  ReadData,
    input  Ready
  );

  modport slave (
    input  ReadRegister,
    input  WriteRegister,
    input  WriteData,
    input  RegWrite,
    output ReadData,
    output Ready
  );
endinterface

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
//   Parametrised register file for the decode stage.
//   - After reset a sequencer writes zero to every register, one per clock;
//     Ready rises once all DEPTH registers have been cleared.
//   - One write port (driven by writeback), NUM_READ combinational read ports.
//   - Optional same-cycle write-to-read bypass (BYPASS=1).
//   - Optional hardwired-zero register (ZERO_REG < DEPTH enables it).
//
//   Ports:
//     clk    : clock, all state changes on posedge
//     reset  : synchronous, active-high; restarts the clear sequence but
//              leaves the array untouched on that edge
//     rf     : regfile_bypass_if.slave (addresses, write data, ReadData, Ready)
// ---------------------------------------------------------------------------
module regfile_bypass #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  regfile_bypass_if.slave  rf
);

  // Array index width; an address is only used as an index after it has
  // been range-checked against DEPTH, so dropping the upper bits is safe.
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]       DEPTH_U = 32'(DEPTH);
  localparam bit                ZERO_EN = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_A  = ZERO_EN ? ADDR_W'(ZERO_REG) : '0;
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              ready;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH_U;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_EN && (a == ZERO_A);
  endfunction

  // -------------------------------------------------------------------------
  // Clear sequencer. clr_cnt only advances while clearing and simply parks
  // once RUN is reached.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
      if (clr_cnt_reg == LAST_A) begin
        state_reg <= RUN;
      end
    end
  end

  // Ready decodes a single state flop, so it cannot glitch.
  assign ready    = (state_reg == RUN);
  assign rf.Ready = ready;

  // -------------------------------------------------------------------------
  // Write path. The clear sequencer and the writeback port never need the
  // array in the same cycle (writes are only accepted in RUN), so a single
  // muxed write port serves both.
  // -------------------------------------------------------------------------
  logic              write_ok;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  // write_ok deliberately excludes reset: it also qualifies the bypass,
  // which is purely combinational. Only the array update is gated by reset.
  assign write_ok = rf.RegWrite && ready &&
                    !is_zero(rf.WriteRegister) && in_range(rf.WriteRegister);

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_reg == CLEAR) begin
        mem_we  = 1'b1;
        mem_idx = clr_cnt_reg[IDX_W-1:0];
      end else if (write_ok) begin
        mem_we    = 1'b1;
        mem_idx   = rf.WriteRegister[IDX_W-1:0];
        mem_wdata = rf.WriteData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Read ports: independent, combinational. Forcing zero until Ready keeps
  // uninitialised array contents from ever reaching the datapath.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = rf.ReadRegister[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd = '0;
        if (!ready) begin
          rd = '0;
        end else if (is_zero(ra) || !in_range(ra)) begin
          rd = '0;
        end else if ((BYPASS != 0) && write_ok && (rf.WriteRegister == ra)) begin
          rd = rf.WriteData;
        end else begin
          rd = mem[ra[IDX_W-1:0]];
        end
      end

      assign rf.ReadData[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_bypass.sv
// ---------------------------------------------------------------------------
// tb_regfile_bypass
//   Three instances: 64x32 with bypass, 64x32 without bypass (same stimulus),
//   and a 32-bit, 24-deep, 4-read-port file with register 0 hardwired.
//   Reference models are plain arrays plus a "clock edges since reset" count.
// ---------------------------------------------------------------------------
module tb_regfile_bypass;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_m;
  logic rst_p;

  regfile_bypass_if #(.DATA_W(64), .ADDR_W(5), .NUM_READ(2)) if_b ();
  regfile_bypass_if #(.DATA_W(64), .ADDR_W(5), .NUM_READ(2)) if_n ();
  regfile_bypass_if #(.DATA_W(32), .ADDR_W(5), .NUM_READ(4)) if_p ();

  // The no-bypass instance mirrors the bypass instance's inputs.
  assign if_n.ReadRegister  = if_b.ReadRegister;
  assign if_n.WriteRegister = if_b.WriteRegister;
  assign if_n.WriteData     = if_b.WriteData;
  assign if_n.RegWrite      = if_b.RegWrite;

  regfile_bypass #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .NUM_READ(2),
                   .ZERO_REG(31), .BYPASS(1)) dut_b (
    .clk(clk), .reset(rst_m), .rf(if_b));

  regfile_bypass #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .NUM_READ(2),
                   .ZERO_REG(31), .BYPASS(0)) dut_n (
    .clk(clk), .reset(rst_m), .rf(if_n));

  regfile_bypass #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .NUM_READ(4),
                   .ZERO_REG(0), .BYPASS(1)) dut_p (
    .clk(clk), .reset(rst_p), .rf(if_p));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- 64x32 model ----------------
  localparam logic [63:0] PAT = 64'h0000010204080001;
  logic [63:0] mm [32];
  int          m_cnt   = 0;
  bit          m_valid = 1'b0;

  function automatic logic [63:0] m_exp(input logic [4:0] a, input bit bp,
                                        input logic we, input logic [4:0] wa,
                                        input logic [63:0] wd);
    if (m_cnt < 32) return 64'h0;
    if (a == 5'd31) return 64'h0;
    if (bp && we && wa != 5'd31 && wa == a) return wd;
    return mm[a];
  endfunction

  task automatic m_cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0] ra [2];
    ra[0] = ra0;
    ra[1] = ra1;
    rst_m              = rst;
    if_b.RegWrite      = we;
    if_b.WriteRegister = wa;
    if_b.WriteData     = wd;
    if_b.ReadRegister  = {ra1, ra0};
    #2;
    if (m_valid) begin
      check("ready_byp", 64'(if_b.Ready), 64'(m_cnt >= 32));
      check("ready_nobyp", 64'(if_n.Ready), 64'(m_cnt >= 32));
      for (int p = 0; p < 2; p++) begin
        check($sformatf("rd%0d_byp a=%0d", p, ra[p]), if_b.ReadData[p*64 +: 64],
              m_exp(ra[p], 1'b1, we, wa, wd));
        check($sformatf("rd%0d_nobyp a=%0d", p, ra[p]), if_n.ReadData[p*64 +: 64],
              m_exp(ra[p], 1'b0, we, wa, wd));
      end
    end
    @(posedge clk);
    if (rst) begin
      m_cnt = 0;
    end else if (m_cnt < 32) begin
      m_cnt++;
      if (m_cnt == 32) for (int i = 0; i < 32; i++) mm[i] = 64'h0;
    end else if (we && wa != 5'd31) begin
      mm[wa] = wd;
    end
    m_valid = m_valid || rst;
    #1;
  endtask

  task automatic m_rand_read_cycle(input logic we, input logic [4:0] wa, input logic [63:0] wd);
    m_cycle(1'b0, we, wa, wd, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  // Counts edges with reset low until the bypass instance reports Ready.
  task automatic m_wait_ready(input string tag);
    int edges = 0;
    while (edges < 100) begin
      // Random writes here also exercise "writes during clear are dropped".
      m_rand_read_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        {$urandom, $urandom});
      edges++;
      if (if_b.Ready === 1'b1) break;
    end
    check(tag, 64'(edges), 64'd32);
  endtask

  // ---------------- 32x24, 4-port model ----------------
  logic [31:0] pm [24];
  int          p_cnt   = 0;
  bit          p_valid = 1'b0;

  function automatic logic [31:0] p_exp(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (p_cnt < 24) return 32'h0;
    if (a == 5'd0 || a >= 5'd24) return 32'h0;
    if (we && wa != 5'd0 && wa < 5'd24 && wa == a) return wd;
    return pm[a];
  endfunction

  task automatic p_cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [19:0] ras);
    rst_p              = rst;
    if_p.RegWrite      = we;
    if_p.WriteRegister = wa;
    if_p.WriteData     = wd;
    if_p.ReadRegister  = ras;
    #2;
    if (p_valid) begin
      check("ready_p", 64'(if_p.Ready), 64'(p_cnt >= 24));
      for (int p = 0; p < 4; p++) begin
        check($sformatf("rd%0d_p a=%0d", p, ras[p*5 +: 5]), 64'(if_p.ReadData[p*32 +: 32]),
              64'(p_exp(ras[p*5 +: 5], we, wa, wd)));
      end
    end
    @(posedge clk);
    if (rst) begin
      p_cnt = 0;
    end else if (p_cnt < 24) begin
      p_cnt++;
      if (p_cnt == 24) for (int i = 0; i < 24; i++) pm[i] = 32'h0;
    end else if (we && wa != 5'd0 && wa < 5'd24) begin
      pm[wa] = wd;
    end
    p_valid = p_valid || rst;
    #1;
  endtask

  function automatic logic [19:0] rand_ras();
    logic [19:0] r;
    for (int p = 0; p < 4; p++) r[p*5 +: 5] = 5'($urandom_range(0, 31));
    return r;
  endfunction

  initial begin
    rst_p              = 1'b1;
    if_p.RegWrite      = 1'b0;
    if_p.WriteRegister = '0;
    if_p.WriteData     = '0;
    if_p.ReadRegister  = '0;
    @(posedge clk);
    #1;

    // 1. Reset held two cycles, then count the clear sequence.
    m_cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd1);
    m_cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd2, 5'd3);
    // 2b. Write to reg 5 right at the start of clear; must be dropped.
    m_cycle(1'b0, 1'b1, 5'd5, 64'h5555, 5'd5, 5'd5);
    begin
      int edges = 1;
      while (edges < 100 && if_b.Ready !== 1'b1) begin
        m_rand_read_cycle(1'b1, 5'd5, 64'h5555);
        edges++;
      end
      check("edges_to_ready", 64'(edges), 64'd32);
    end
    for (int i = 0; i < 32; i++) m_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));

    // 2a. Writes to the zero register are dropped.
    m_cycle(1'b0, 1'b1, 5'd31, 64'hA0, 5'd31, 5'd31);
    m_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31);

    // 3. Pattern fill and sweep.
    for (int i = 0; i < 31; i++) m_rand_read_cycle(1'b1, 5'(i), 64'(i) * PAT);
    for (int i = 1; i < 32; i++) m_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'(i - 1), 5'(i));

    // 4. Bypass vs. no bypass on the same write.
    m_cycle(1'b0, 1'b1, 5'd7, 64'hDEADBEEF, 5'd7, 5'd7);
    m_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'd7, 5'd6);

    // 5a. Reset at clr_cnt=10.
    m_cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) m_rand_read_cycle(1'b0, 5'd0, 64'h0);
    m_cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    m_wait_ready("edges_after_midclear_reset");

    // 5b. Reset in RUN after writing reg 3.
    m_cycle(1'b0, 1'b1, 5'd3, 64'h55, 5'd3, 5'd2);
    m_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
    m_cycle(1'b1, 1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
    m_wait_ready("edges_after_run_reset");
    m_cycle(1'b0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd3);

    // Random traffic, with reads biased toward the write address.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      logic [4:0] ra0;
      wa  = 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      m_cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), wa,
              {$urandom, $urandom}, ra0, 5'($urandom_range(0, 31)));
    end

    // 6. Parametrised instance.
    rst_m = 1'b1;
    p_cycle(1'b1, 1'b0, 5'd0, 32'h0, 20'h0);
    begin
      int edges = 0;
      while (edges < 100) begin
        p_cycle(1'b0, 1'b1, 5'd9, 32'hFFFF, rand_ras());
        edges++;
        if (if_p.Ready === 1'b1) break;
      end
      check("edges_to_ready_p", 64'(edges), 64'd24);
    end
    p_cycle(1'b0, 1'b1, 5'd25, 32'hBAD, {4{5'd25}});
    p_cycle(1'b0, 1'b0, 5'd0, 32'h0, {4{5'd25}});
    p_cycle(1'b0, 1'b1, 5'd0, 32'hBAD0, {4{5'd0}});
    p_cycle(1'b0, 1'b1, 5'd9, 32'h1234, {4{5'd9}});
    p_cycle(1'b0, 1'b0, 5'd0, 32'h0, {4{5'd9}});
    for (int n = 0; n < 200; n++) begin
      p_cycle(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, rand_ras());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
